dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store unit (port A) and a loader/DMA engine (port B).
- Sits in front of the memory controller that decodes addresses into data RAM (region 0, below `MEM0_LIMIT`) and the 16-bit peripheral memory (region 1).
- Provides round-robin arbitration, a req/ack handshake per port and region-dependent wait states.

---
 rtl/dmem_arb_pkg.sv | 26 ++
 rtl/dmem_arbiter.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        ACK    = 2'd3
    } arb_state_t;

    // Requester identity: core load/store unit (A) or loader/DMA engine (B).
    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_t;

    // First byte address of the 16-bit peripheral region (region 1).
    localparam logic [31:0] DEFAULT_MEM0_LIMIT = 32'd4096;

    // The requester that is not 'id'.
    function automatic req_id_t other_port(input req_id_t id);
        return (id == REQ_A) ? REQ_B : REQ_A;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the core LSU (A)
// and the loader/DMA engine (B), with region-dependent wait states.
// The memory-side bus is driven from registers and is forced to zero
// whenever no access is in flight.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter logic [31:0] MEM0_LIMIT = DEFAULT_MEM0_LIMIT,
    parameter int unsigned MEM1_WAIT  = 32'd2
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        a_req,
    input  logic        a_rw,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_rw,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic [31:0] b_rdata,
    output logic        m_valid,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    output logic        m_rw,
    input  logic [31:0] m_rdata,
    output logic        busy
);

    // Wait counter is wide enough for MEM1_WAIT and never narrower than 1 bit.
    localparam int unsigned      CNT_W    = (MEM1_WAIT > 32'd0) ? $clog2(MEM1_WAIT + 32'd1) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM1_WAIT);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);

    arb_state_t       state_q;
    req_id_t          last_grant_q;
    req_id_t          winner_q;
    logic [CNT_W-1:0] cnt_q;
    logic             m_valid_q;
    logic [31:0]      m_addr_q;
    logic [31:0]      m_wdata_q;
    logic             m_rw_q;
    logic             a_ack_q;
    logic             b_ack_q;
    logic [31:0]      a_rdata_q;
    logic [31:0]      b_rdata_q;
    logic             busy_q;

    logic             sel_valid_s;
    req_id_t          sel_id_s;
    logic             sel_rw_s;
    logic [31:0]      sel_addr_s;
    logic [31:0]      sel_wdata_s;
    logic             need_wait_s;
    logic             last_access_s;

    // The latched address is held on m_addr_q for the whole access, so the
    // region decision can be taken straight from it.
    assign need_wait_s   = (m_addr_q >= MEM0_LIMIT) && (CNT_LOAD != CNT_ZERO);
    assign last_access_s = ((state_q == ACCESS) && !need_wait_s) ||
                           ((state_q == WAIT) && (cnt_q == CNT_ONE));

    // Decide which port (if any) starts an access at the next edge.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = REQ_A;
        case (state_q)
            IDLE: begin
                if (a_req && b_req) begin
                    sel_valid_s = 1'b1;
                    sel_id_s    = other_port(last_grant_q);
                end else if (a_req) begin
                    sel_valid_s = 1'b1;
                    sel_id_s    = REQ_A;
                end else if (b_req) begin
                    sel_valid_s = 1'b1;
                    sel_id_s    = REQ_B;
                end else begin
                    sel_valid_s = 1'b0;
                    sel_id_s    = REQ_A;
                end
            end
            ACK: begin
                // The winner's payload is stale here; only the loser may chain.
                sel_id_s    = other_port(winner_q);
                sel_valid_s = (winner_q == REQ_A) ? b_req : a_req;
            end
            default: begin
                sel_valid_s = 1'b0;
                sel_id_s    = REQ_A;
            end
        endcase
    end

    // Payload mux for the selected port.
    always_comb begin
        sel_rw_s    = 1'b0;
        sel_addr_s  = 32'd0;
        sel_wdata_s = 32'd0;
        if (sel_id_s == REQ_B) begin
            sel_rw_s    = b_rw;
            sel_addr_s  = b_addr;
            sel_wdata_s = b_wdata;
        end else begin
            sel_rw_s    = a_rw;
            sel_addr_s  = a_addr;
            sel_wdata_s = a_wdata;
        end
    end

    // Arbitration FSM, wait-state counter and all registered outputs.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= IDLE;
            last_grant_q <= REQ_B;
            winner_q     <= REQ_A;
            cnt_q        <= CNT_ZERO;
            m_valid_q    <= 1'b0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            m_rw_q       <= 1'b0;
            a_ack_q      <= 1'b0;
            b_ack_q      <= 1'b0;
            a_rdata_q    <= 32'd0;
            b_rdata_q    <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            a_ack_q <= 1'b0;
            b_ack_q <= 1'b0;
            case (state_q)
                IDLE, ACK: begin
                    if (sel_valid_s) begin
                        state_q   <= ACCESS;
                        winner_q  <= sel_id_s;
                        m_valid_q <= 1'b1;
                        m_addr_q  <= sel_addr_s;
                        m_wdata_q <= sel_wdata_s;
                        m_rw_q    <= sel_rw_s;
                        busy_q    <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ACCESS, WAIT: begin
                    if (last_access_s) begin
                        state_q      <= ACK;
                        cnt_q        <= CNT_ZERO;
                        last_grant_q <= winner_q;
                        m_valid_q    <= 1'b0;
                        m_addr_q     <= 32'd0;
                        m_wdata_q    <= 32'd0;
                        m_rw_q       <= 1'b0;
                        if (winner_q == REQ_A) begin
                            a_ack_q <= 1'b1;
                        end else begin
                            b_ack_q <= 1'b1;
                        end
                        // Read data is captured on the edge closing the access.
                        if (!m_rw_q) begin
                            if (winner_q == REQ_A) begin
                                a_rdata_q <= m_rdata;
                            end else begin
                                b_rdata_q <= m_rdata;
                            end
                        end
                    end else if (state_q == ACCESS) begin
                        state_q <= WAIT;
                        cnt_q   <= CNT_LOAD;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    cnt_q     <= CNT_ZERO;
                    m_valid_q <= 1'b0;
                    m_addr_q  <= 32'd0;
                    m_wdata_q <= 32'd0;
                    m_rw_q    <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign a_ack   = a_ack_q;
    assign b_ack   = b_ack_q;
    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;
    assign m_valid = m_valid_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_rw    = m_rw_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a scoreboard of expected acks,
// a table of single-requester accesses and hand-written corner sequences.
module tb_dmem_arbiter;

    logic        CLK     = 1'b0;
    logic        RESET_N = 1'b0;
    logic        a_req = 1'b0, a_rw = 1'b0;
    logic [31:0] a_addr = 32'd0, a_wdata = 32'd0;
    logic        b_req = 1'b0, b_rw = 1'b0;
    logic [31:0] b_addr = 32'd0, b_wdata = 32'd0;
    logic        a_ack, b_ack, m_valid, m_rw, busy;
    logic [31:0] a_rdata, b_rdata, m_addr, m_wdata, m_rdata;

    // Second build with MEM1_WAIT = 0, driven only on port A.
    logic        c_req = 1'b0;
    logic [31:0] c_addr = 32'd0;
    logic        d0_a_ack, d0_b_ack, d0_m_valid, d0_m_rw, d0_busy;
    logic [31:0] d0_a_rdata, d0_b_rdata, d0_m_addr, d0_m_wdata, d0_m_rdata;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int vcnt = 0;
    logic [31:0] mdl_a = 32'd0;
    logic [31:0] mdl_b = 32'd0;

    typedef struct {
        bit          port;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          exp_ack;
        int          nval;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        bit          port;
        bit          rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [31:0] mem_model(input logic [31:0] addr);
        if (addr == 32'h0000_0010) return 32'hDEAD_BEEF;
        return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign m_rdata    = m_valid ? mem_model(m_addr) : 32'd0;
    assign d0_m_rdata = d0_m_valid ? mem_model(d0_m_addr) : 32'd0;

    dmem_arbiter #(.MEM0_LIMIT(32'd4096), .MEM1_WAIT(32'd2)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .a_req(a_req), .a_rw(a_rw), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_rw(b_rw), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_ack(b_ack), .b_rdata(b_rdata),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_rw(m_rw),
        .m_rdata(m_rdata), .busy(busy)
    );

    dmem_arbiter #(.MEM0_LIMIT(32'd4096), .MEM1_WAIT(32'd0)) dut0 (
        .CLK(CLK), .RESET_N(RESET_N),
        .a_req(c_req), .a_rw(1'b0), .a_addr(c_addr), .a_wdata(32'd0),
        .a_ack(d0_a_ack), .a_rdata(d0_a_rdata),
        .b_req(1'b0), .b_rw(1'b0), .b_addr(32'd0), .b_wdata(32'd0),
        .b_ack(d0_b_ack), .b_rdata(d0_b_rdata),
        .m_valid(d0_m_valid), .m_addr(d0_m_addr), .m_wdata(d0_m_wdata), .m_rw(d0_m_rw),
        .m_rdata(d0_m_rdata), .busy(d0_busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input bit port, input bit rw, input logic [31:0] addr,
                            input logic [31:0] wdata, input int ack_cyc, input int nval);
        exp_t e;
        if (!rw) begin
            if (port) mdl_b = mem_model(addr);
            else      mdl_a = mem_model(addr);
        end
        e.port = port; e.rw = rw; e.addr = addr; e.wdata = wdata;
        e.exp_ack = ack_cyc; e.nval = nval; e.exp_a = mdl_a; e.exp_b = mdl_b;
        sb_q.push_back(e);
    endtask

    // Raise a request, wait (bounded) for its ack, then drop or keep req.
    task automatic drive_one(input bit port, input bit rw, input logic [31:0] addr,
                             input logic [31:0] wdata, input bit keep);
        bit got = 1'b0;
        if (port) begin b_rw = rw; b_addr = addr; b_wdata = wdata; b_req = 1'b1; end
        else      begin a_rw = rw; a_addr = addr; a_wdata = wdata; a_req = 1'b1; end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge CLK);
            got = port ? b_ack : a_ack;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL ack_timeout: port %0d saw no ack in 40 cycles, expected one", port);
        end
        @(posedge CLK); #1;
        if (!keep) begin
            if (port) b_req = 1'b0; else a_req = 1'b0;
        end
    endtask

    // Scoreboard monitor: bus checks while active, ack pop-and-compare.
    always @(negedge CLK) begin : mon
        exp_t e;
        logic in_win;
        if (RESET_N) begin
            if (!m_valid) begin
                check("m_addr_idle", m_addr, 32'd0);
                check("m_wdata_idle", m_wdata, 32'd0);
                check("m_rw_idle", {31'd0, m_rw}, 32'd0);
            end else if (sb_q.size() != 0) begin
                vcnt++;
                check("m_addr", m_addr, sb_q[0].addr);
                check("m_rw", {31'd0, m_rw}, {31'd0, sb_q[0].rw});
                if (sb_q[0].rw) check("m_wdata", m_wdata, sb_q[0].wdata);
                in_win = (cyc >= sb_q[0].exp_ack - sb_q[0].nval) && (cyc < sb_q[0].exp_ack);
                check("m_valid_window", {31'd0, in_win}, 32'd1);
            end
            check("dual_ack", {31'd0, a_ack & b_ack}, 32'd0);
            if (a_ack || b_ack) begin
                if (sb_q.size() == 0) begin
                    check("spurious_ack", {30'd0, a_ack, b_ack}, 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_port", {31'd0, b_ack}, {31'd0, e.port});
                    check("ack_cycle", cyc, e.exp_ack);
                    check("a_rdata", a_rdata, e.exp_a);
                    check("b_rdata", b_rdata, e.exp_b);
                    check("valid_cycles", vcnt, e.nval);
                    vcnt = 0;
                end
            end
        end
    end

    initial begin
        int k0;
        int lat;
        // port, rw, addr, wdata, expected ack latency from cycle 0
        vecs[0] = '{1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 2};
        vecs[1] = '{1'b1, 1'b1, 32'h0000_1000, 32'hCAFE_1234, 4};
        vecs[2] = '{1'b0, 1'b0, 32'h0000_0FFF, 32'h0000_0000, 2};
        vecs[3] = '{1'b0, 1'b0, 32'h0000_1000, 32'h0000_0000, 4};
        vecs[4] = '{1'b1, 1'b0, 32'h2000_0000, 32'h0000_0000, 4};
        vecs[5] = '{1'b0, 1'b1, 32'h0000_0020, 32'h1111_2222, 2};
        vecs[6] = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 2};
        vecs[7] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 4};

        // Reset state
        RESET_N = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_a_ack", {31'd0, a_ack}, 32'd0);
        check("rst_b_ack", {31'd0, b_ack}, 32'd0);
        check("rst_a_rdata", a_rdata, 32'd0);
        check("rst_b_rdata", b_rdata, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        RESET_N = 1'b1;

        // Contention straight after reset: A first, B chained 2 cycles later
        @(posedge CLK); #1;
        k0 = cyc;
        push_exp(1'b0, 1'b0, 32'h0000_0040, 32'd0, k0 + 2, 1);
        push_exp(1'b1, 1'b0, 32'h0000_0080, 32'd0, k0 + 4, 1);
        fork
            drive_one(1'b0, 1'b0, 32'h0000_0040, 32'd0, 1'b0);
            drive_one(1'b1, 1'b0, 32'h0000_0080, 32'd0, 1'b0);
        join

        // Table of single-requester accesses from IDLE
        for (int i = 0; i < 8; i++) begin
            @(posedge CLK); #1;
            push_exp(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                     cyc + vecs[i].lat, vecs[i].lat - 1);
            drive_one(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0);
            check("busy_after", {31'd0, busy}, 32'd0);
        end

        // Reset during WAIT: access abandoned, outputs cleared at once
        @(posedge CLK); #1;
        a_rw = 1'b0; a_addr = 32'h0000_1000; a_req = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_m_valid", {31'd0, m_valid}, 32'd1);
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_m_valid", {31'd0, m_valid}, 32'd0);
        check("arst_m_addr", m_addr, 32'd0);
        check("arst_a_ack", {31'd0, a_ack}, 32'd0);
        check("arst_a_rdata", a_rdata, 32'd0);
        check("arst_b_rdata", b_rdata, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        a_req = 1'b0;
        mdl_a = 32'd0;
        mdl_b = 32'd0;
        repeat (3) @(posedge CLK);
        #1;
        RESET_N = 1'b1;

        // Fairness: both hold requests for 8 transactions, A wins first
        @(posedge CLK); #1;
        k0 = cyc;
        for (int i = 0; i < 8; i++) begin
            push_exp(i[0], 1'b0,
                     i[0] ? (32'h0000_0200 + 32'(4 * (i / 2))) : (32'h0000_0100 + 32'(4 * (i / 2))),
                     32'd0, k0 + 2 + 2 * i, 1);
        end
        fork
            begin
                for (int i = 0; i < 4; i++)
                    drive_one(1'b0, 1'b0, 32'h0000_0100 + 32'(4 * i), 32'd0, i < 3);
            end
            begin
                for (int j = 0; j < 4; j++)
                    drive_one(1'b1, 1'b0, 32'h0000_0200 + 32'(4 * j), 32'd0, j < 3);
            end
        join

        // MEM1_WAIT = 0 build: both sides of the boundary take 2 cycles
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK); #1;
            c_addr = (i == 0) ? 32'h0000_0FFF : 32'h0000_1000;
            c_req  = 1'b1;
            k0     = cyc;
            lat    = -1;
            for (int k = 0; k < 20 && lat < 0; k++) begin
                @(negedge CLK);
                if (d0_a_ack) lat = cyc - k0;
            end
            @(posedge CLK); #1;
            c_req = 1'b0;
            check("w0_latency", 32'(lat), 32'd2);
            check("w0_rdata", d0_a_rdata, mem_model(c_addr));
        end

        repeat (3) @(posedge CLK);
        #1;
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
